// File: rtl/dmem_result_reader_pkg.sv
// Shared types and defaults for dmem_result_reader.
// DMEM_READER_CHECKSUM_EN widens the state encoding to make room for S_CSUM.
package dmem_result_reader_pkg;

`ifdef DMEM_READER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_SEND = 3'd2,
    S_FIN  = 3'd3,
    S_CSUM = 3'd4
  } state_t;

  localparam state_t S_TAIL = S_CSUM;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam state_t S_TAIL = S_FIN;
`endif

  localparam logic [31:0] DEF_BASE_ADDR = 32'd80;
  localparam int          DEF_NUM_WORDS = 20;

  // Next word address; wraps modulo 2^32 by construction.
  function automatic logic [31:0] word_step(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/dmem_result_reader.sv
// Streams NUM_WORDS words from dmem starting at BASE_ADDR over valid/ready.
// Optional DMEM_READER_CHECKSUM_EN appends a modular-sum word as the last word.
module dmem_result_reader
  import dmem_result_reader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          NUM_WORDS = DEF_NUM_WORDS,
  parameter int          CNT_W     = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] mem_rd_addr,
  input  logic [31:0] mem_rd_data,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((NUM_WORDS == 0) ? 0 : NUM_WORDS - 1);
  localparam bit               EMPTY    = (NUM_WORDS == 0);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             at_last;

`ifdef DMEM_READER_CHECKSUM_EN
  logic [31:0] sum;
`endif

  assign accept  = out_valid && out_ready;
  assign at_last = (count == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = EMPTY ? S_TAIL : S_READ;
      S_READ: state_nxt = S_SEND;
      S_SEND: if (accept) state_nxt = at_last ? S_TAIL : S_READ;
`ifdef DMEM_READER_CHECKSUM_EN
      S_CSUM: if (accept) state_nxt = S_FIN;
`endif
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rd_addr <= BASE_ADDR;
      out_data    <= 32'd0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      count       <= '0;
`ifdef DMEM_READER_CHECKSUM_EN
      sum         <= 32'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            count       <= '0;
            mem_rd_addr <= BASE_ADDR;
`ifdef DMEM_READER_CHECKSUM_EN
            sum <= 32'd0;
            // An empty dump still emits the (zero) checksum word.
            if (EMPTY) begin
              out_data  <= 32'd0;
              out_valid <= 1'b1;
              out_last  <= 1'b1;
            end
`endif
          end
        end
        S_READ: begin
          out_data  <= mem_rd_data;
          out_valid <= 1'b1;
`ifdef DMEM_READER_CHECKSUM_EN
          out_last  <= 1'b0;
          sum       <= sum + mem_rd_data;
`else
          out_last  <= at_last;
`endif
        end
        S_SEND: begin
          if (accept) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (!at_last) begin
              count       <= count + CNT_W'(1);
              mem_rd_addr <= word_step(mem_rd_addr);
            end
`ifdef DMEM_READER_CHECKSUM_EN
            else begin
              out_data  <= sum;
              out_valid <= 1'b1;
              out_last  <= 1'b1;
            end
`endif
          end
        end
`ifdef DMEM_READER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
`endif
        S_FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
